// File: rtl/ts_os_gen.sv
// Per-lane TS1/TS2 training ordered-set generator.
// Emits back-to-back 16-symbol ordered sets towards the 8b10b encoder on
// command from the LTSSM, counts completed sets and flags burst completion.
module ts_os_gen #(
    parameter int NTS = 1024,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic          os_type,
    input  logic [7:0]    link_num,
    input  logic          link_pad,
    input  logic [4:0]    lane_num,
    input  logic          lane_pad,
    input  logic [7:0]    n_fts,
    input  logic [7:0]    rate_id,
    input  logic [7:0]    train_ctl,
    input  logic          sym_ready,
    output logic [7:0]    txdata,
    output logic          txdatak,
    output logic          txvalid,
    output logic          txelecidle,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] os_count
);

    localparam logic [7:0]    SYM_COM  = 8'hBC;   // K28.5
    localparam logic [7:0]    SYM_PAD  = 8'hF7;   // K23.7
    localparam logic [7:0]    SYM_TS1  = 8'h4A;   // D10.2
    localparam logic [7:0]    SYM_TS2  = 8'h45;   // D5.2
    localparam logic [3:0]    LAST_IDX = 4'd15;
    localparam logic [CW-1:0] NTS_C    = CW'(NTS);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FINISH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0] sym_idx;
    logic       stop_pend;

    // Field values frozen for the duration of one ordered set
    logic [7:0] link_num_r;
    logic       link_pad_r;
    logic [4:0] lane_num_r;
    logic       lane_pad_r;
    logic [7:0] n_fts_r;
    logic [7:0] rate_id_r;
    logic [7:0] train_ctl_r;
    logic       os_type_r;

    logic       accept;
    logic       set_end;
    logic       last_set;
    logic       burst_start;
    logic       load_fields;
    logic [7:0] sym_data;
    logic       sym_k;

    assign accept      = (state == SEND) && sym_ready;
    assign set_end     = accept && (sym_idx == LAST_IDX);
    assign last_set    = (os_count + ONE_C) == NTS_C;
    assign burst_start = (state == IDLE) && start;
    // Fields are captured on burst start and again whenever a set rolls
    // straight into the next one, i.e. exactly when symbol 0 goes out.
    assign load_fields = burst_start || (set_end && (state_nx == SEND));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decision; a stop seen at any point of the set ends the burst
    // at the set boundary, and reaching the count always wins over stop
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (set_end && (last_set || stop || stop_pend)) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Symbol index, set counter and pending-stop tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_idx   <= '0;
            os_count  <= '0;
            stop_pend <= 1'b0;
        end else begin
            if (burst_start) begin
                sym_idx   <= '0;
                os_count  <= '0;
                stop_pend <= stop;
            end else if (state == SEND) begin
                stop_pend <= stop_pend | stop;
                if (accept) begin
                    // 4-bit index wraps 15 -> 0 with no idle gap between sets
                    sym_idx <= sym_idx + 4'd1;
                end
                if (set_end && (os_count != NTS_C)) begin
                    os_count <= os_count + ONE_C;
                end
            end
        end
    end

    // Field latches, refreshed only at symbol 0 of each set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            link_num_r  <= '0;
            link_pad_r  <= 1'b0;
            lane_num_r  <= '0;
            lane_pad_r  <= 1'b0;
            n_fts_r     <= '0;
            rate_id_r   <= '0;
            train_ctl_r <= '0;
            os_type_r   <= 1'b0;
        end else if (load_fields) begin
            link_num_r  <= link_num;
            link_pad_r  <= link_pad;
            lane_num_r  <= lane_num;
            lane_pad_r  <= lane_pad;
            n_fts_r     <= n_fts;
            rate_id_r   <= rate_id;
            train_ctl_r <= train_ctl;
            os_type_r   <= os_type;
        end
    end

    // Ordered-set symbol map indexed by position within the set
    always_comb begin
        sym_data = '0;
        sym_k    = 1'b0;
        unique case (sym_idx)
            4'd0: begin
                sym_data = SYM_COM;
                sym_k    = 1'b1;
            end
            4'd1: begin
                sym_data = link_pad_r ? SYM_PAD : link_num_r;
                sym_k    = link_pad_r;
            end
            4'd2: begin
                sym_data = lane_pad_r ? SYM_PAD : {3'b000, lane_num_r};
                sym_k    = lane_pad_r;
            end
            4'd3: sym_data = n_fts_r;
            4'd4: sym_data = rate_id_r;
            4'd5: sym_data = train_ctl_r;
            default: sym_data = os_type_r ? SYM_TS2 : SYM_TS1;
        endcase
    end

    // Outputs decoded from state; IDLE yields the reset values
    always_comb begin
        txdata     = '0;
        txdatak    = 1'b0;
        txvalid    = 1'b0;
        txelecidle = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            SEND: begin
                txdata     = sym_data;
                txdatak    = sym_k;
                txvalid    = 1'b1;
                txelecidle = 1'b0;
                busy       = 1'b1;
            end
            FINISH: begin
                txelecidle = 1'b0;
                busy       = 1'b1;
                done       = (os_count == NTS_C);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ts_os_gen.sv
module tb_ts_os_gen;

    localparam int NTS = 4;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          os_type = 1'b0;
    logic [7:0]    link_num = 8'h01;
    logic          link_pad = 1'b0;
    logic [4:0]    lane_num = 5'd3;
    logic          lane_pad = 1'b0;
    logic [7:0]    n_fts = 8'h20;
    logic [7:0]    rate_id = 8'h02;
    logic [7:0]    train_ctl = 8'h00;
    logic          sym_ready = 1'b1;
    logic [7:0]    txdata;
    logic          txdatak;
    logic          txvalid;
    logic          txelecidle;
    logic          busy;
    logic          done;
    logic [CW-1:0] os_count;

    ts_os_gen #(.NTS(NTS), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .os_type(os_type), .link_num(link_num), .link_pad(link_pad),
        .lane_num(lane_num), .lane_pad(lane_pad), .n_fts(n_fts),
        .rate_id(rate_id), .train_ctl(train_ctl), .sym_ready(sym_ready),
        .txdata(txdata), .txdatak(txdatak), .txvalid(txvalid),
        .txelecidle(txelecidle), .busy(busy), .done(done), .os_count(os_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: a burst is a stream of sets; each set is a 16-entry
    // symbol table built from the inputs present when its symbol 0 goes out.
    bit       m_send = 0;
    bit       m_fin = 0;
    bit       m_stop = 0;
    int       m_acc = 0;
    int       m_sets = 0;
    int       md [16];
    bit       mk [16];

    function automatic void build_set();
        md[0] = 'hBC; mk[0] = 1;
        md[1] = link_pad ? 'hF7 : int'(link_num); mk[1] = link_pad;
        md[2] = lane_pad ? 'hF7 : int'(lane_num); mk[2] = lane_pad;
        md[3] = n_fts;     mk[3] = 0;
        md[4] = rate_id;   mk[4] = 0;
        md[5] = train_ctl; mk[5] = 0;
        for (int i = 6; i < 16; i++) begin
            md[i] = os_type ? 'h45 : 'h4A;
            mk[i] = 0;
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_send = 0; m_fin = 0; m_stop = 0; m_acc = 0; m_sets = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_send) begin
            m_stop = m_stop | stop;
            if (sym_ready) begin
                m_acc++;
                if (m_acc == 16) begin
                    m_acc = 0;
                    m_sets = (m_sets + 1 > NTS) ? NTS : m_sets + 1;
                    if (m_sets == NTS || m_stop) begin
                        m_send = 0;
                        m_fin = 1;
                    end else begin
                        build_set();
                    end
                end
            end
        end else if (start) begin
            m_send = 1; m_acc = 0; m_sets = 0; m_stop = stop;
            build_set();
        end
    end

    // Per-cycle compare plus capture of accepted symbols for literal checks
    int       cyc_n = 0;
    int       n_acc = 0;
    int       n_done = 0;
    int       t_last_acc = 0;
    int       t_done = 0;
    logic [7:0] cap_d [64];
    logic       cap_k [64];

    always @(negedge clk) begin
        cyc_n++;
        cmp("txvalid", txvalid, m_send);
        cmp("txelecidle", txelecidle, !(m_send || m_fin));
        cmp("busy", busy, m_send || m_fin);
        cmp("done", done, m_fin && (m_sets == NTS));
        cmp("os_count", os_count, m_sets);
        if (m_send) begin
            cmp("txdata", txdata, md[m_acc]);
            cmp("txdatak", txdatak, mk[m_acc]);
        end
        if (txvalid && sym_ready && reset_n) begin
            if (n_acc < 64) begin
                cap_d[n_acc] = txdata;
                cap_k[n_acc] = txdatak;
            end
            n_acc++;
            t_last_acc = cyc_n;
        end
        if (done) begin
            n_done++;
            t_done = cyc_n;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        n_acc = 0;
        n_done = 0;
        for (int i = 0; i < 64; i++) begin
            cap_d[i] = 'x;
            cap_k[i] = 1'bx;
        end
    endtask

    task automatic do_start();
        clr_stats();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int k = 0; k < max_cyc && busy; k++) cyc();
        cmp("wait_idle_busy", busy, 0);
        cyc();
    endtask

    logic [7:0] ts1_ref [16];

    initial begin
        ts1_ref[0] = 8'hBC; ts1_ref[1] = 8'h01; ts1_ref[2] = 8'h03;
        ts1_ref[3] = 8'h20; ts1_ref[4] = 8'h02; ts1_ref[5] = 8'h00;
        for (int i = 6; i < 16; i++) ts1_ref[i] = 8'h4A;

        // Reset values
        repeat (3) cyc();
        cmp("rst_txdata", txdata, 0);
        cmp("rst_txvalid", txvalid, 0);
        cmp("rst_txelecidle", txelecidle, 1);
        cmp("rst_busy", busy, 0);
        cmp("rst_os_count", os_count, 0);
        reset_n = 1'b1;
        cyc();

        // Basic TS1 burst of NTS sets
        do_start();
        cmp("lat_txdata", txdata, 'hBC);
        cmp("lat_txdatak", txdatak, 1);
        cmp("lat_busy", busy, 1);
        wait_idle(200);
        cmp("t1_symbols", n_acc, 64);
        cmp("t1_done_pulses", n_done, 1);
        cmp("t1_done_timing", t_done, t_last_acc + 1);
        cmp("t1_os_count", os_count, 4);
        cmp("t1_elecidle", txelecidle, 1);
        for (int i = 0; i < 16; i++) begin
            cmp($sformatf("t1_set0_sym%0d", i), cap_d[i], ts1_ref[i]);
            cmp($sformatf("t1_set3_sym%0d", i), cap_d[48 + i], ts1_ref[i]);
        end
        cmp("t1_k0", cap_k[0], 1);
        cmp("t1_k1", cap_k[1], 0);

        // PAD in link and lane fields
        link_pad = 1'b1; lane_pad = 1'b1;
        do_start();
        wait_idle(200);
        cmp("pad_link_d", cap_d[1], 'hF7);
        cmp("pad_link_k", cap_k[1], 1);
        cmp("pad_lane_d", cap_d[2], 'hF7);
        cmp("pad_lane_k", cap_k[18], 1);
        link_pad = 1'b0; lane_pad = 1'b0;

        // os_type change mid-set takes effect at the next set
        do_start();
        repeat (24) cyc();
        os_type = 1'b1;
        wait_idle(200);
        cmp("ost_set2_sym6", cap_d[22], 'h4A);
        cmp("ost_set2_sym15", cap_d[31], 'h4A);
        cmp("ost_set3_sym6", cap_d[38], 'h45);
        cmp("ost_set4_sym15", cap_d[63], 'h45);
        os_type = 1'b0;

        // Encoder stall at symbol 9
        do_start();
        repeat (9) cyc();
        sym_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            cmp("stall_txdata", txdata, 'h4A);
            cmp("stall_txvalid", txvalid, 1);
        end
        sym_ready = 1'b1;
        wait_idle(200);
        cmp("stall_symbols", n_acc, 64);
        cmp("stall_done", n_done, 1);

        // Stop during set 2
        do_start();
        repeat (21) cyc();
        stop = 1'b1;
        wait_idle(200);
        stop = 1'b0;
        cmp("stop_done", n_done, 0);
        cmp("stop_os_count", os_count, 2);
        cmp("stop_symbols", n_acc, 32);

        // Start and stop together: exactly one set
        clr_stats();
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        wait_idle(200);
        cmp("ss_symbols", n_acc, 16);
        cmp("ss_os_count", os_count, 1);
        cmp("ss_done", n_done, 0);

        // Start while busy is ignored
        do_start();
        repeat (10) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_idle(200);
        cmp("rebusy_symbols", n_acc, 64);

        // Asynchronous reset mid-set 3
        do_start();
        repeat (36) cyc();
        #2 reset_n = 1'b0;
        #1;
        cmp("arst_txvalid", txvalid, 0);
        cmp("arst_txelecidle", txelecidle, 1);
        cmp("arst_busy", busy, 0);
        cmp("arst_os_count", os_count, 0);
        cmp("arst_txdata", txdata, 0);
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();
        do_start();
        cmp("arst_restart_txdata", txdata, 'hBC);
        cmp("arst_restart_os_count", os_count, 0);
        wait_idle(200);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            sym_ready = ($urandom_range(3) != 0);
            start     = ($urandom_range(19) == 0);
            stop      = ($urandom_range(59) == 0);
            os_type   = $urandom_range(1);
            link_pad  = ($urandom_range(7) == 0);
            lane_pad  = ($urandom_range(7) == 0);
            link_num  = 8'($urandom);
            lane_num  = 5'($urandom);
            n_fts     = 8'($urandom);
            rate_id   = 8'($urandom);
            train_ctl = 8'($urandom);
            cyc();
        end
        start = 1'b0; stop = 1'b0; sym_ready = 1'b1;
        wait_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ts_os_gen.md
Name: ts_os_gen

Overview:
- Per-lane training ordered-set generator for the PHY transmit path.
- Sits directly upstream of the per-lane 8b10b encoder and drives its data, K-flag and electrical-idle inputs.
- On command from the LTSSM (entry to POLLING_ACTIVE_START_TS1 and later states), emits back-to-back 16-symbol TS1 or TS2 ordered sets.
- Counts completed sets and signals when the programmed count has been sent.

Parameters:
- NTS, 1024: number of ordered sets sent per start command (legal range 1..65535).
- CW, 16: width of the set counter; must satisfy 2^CW > NTS.

Ports:
- clk  input  1  PIPE/PCLK domain clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begin a burst of NTS sets. Ignored unless idle.
- stop  input  1  level; finish the current set, then go idle without asserting done.
- os_type  input  1  0=TS1, 1=TS2. Sampled only at each set boundary (symbol 0).
- link_num  input  8  link number field.
- link_pad  input  1  1 = send PAD (K23.7) in the link field instead of link_num.
- lane_num  input  5  lane number field.
- lane_pad  input  1  1 = send PAD in the lane field.
- n_fts  input  8  N_FTS field.
- rate_id  input  8  data-rate identifier field.
- train_ctl  input  8  training control field.
- sym_ready  input  1  encoder accepts a symbol this cycle; 0 = stall.
- txdata  output  8  symbol to encoder.
- txdatak  output  1  K-character flag.
- txvalid  output  1  txdata/txdatak are meaningful.
- txelecidle  output  1  request electrical idle on the lane.
- busy  output  1  a burst is in progress.
- done  output  1  one-cycle pulse when the NTS-th set's last symbol is accepted.
- os_count  output  CW  number of completed sets in the current or last burst.

Behaviour:
- Reset values: txdata=0x00, txdatak=0, txvalid=0, txelecidle=1, busy=0, done=0, os_count=0. Internal state is IDLE, sym_idx=0.
- Reset is asynchronous and clears everything immediately, including mid-set. No partial-set completion after reset release.
- States:
  - IDLE: txvalid=0, txelecidle=1. A start pulse loads the field registers and os_type, clears os_count, and moves to SEND.
  - SEND: one symbol per accepted cycle (sym_ready=1), sym_idx 0..15.
  - FINISH: one cycle; pulses done when applicable, then returns to IDLE.
- Latency: start high at edge N -> txvalid=1, txdata=0xBC (COM, K28.5), txdatak=1, txelecidle=0 after edge N; busy=1 from the same edge.
- Symbol map (idx: data, k):
  - 0: 0xBC, k=1.
  - 1: link_pad ? 0xF7, k=1 : link_num, k=0.
  - 2: lane_pad ? 0xF7, k=1 : {3'b0, lane_num}, k=0.
  - 3: n_fts, k=0.
  - 4: rate_id, k=0.
  - 5: train_ctl, k=0.
  - 6-15: 0x4A (D10.2) for TS1 or 0x45 (D5.2) for TS2, k=0.
- Field inputs and os_type are latched at symbol 0 of every set. They are stable within a set; a change takes effect at the next set.
- Stall: sym_ready=0 holds txdata, txdatak, sym_idx and os_count unchanged; txvalid stays 1.
- Set completion: the cycle symbol 15 is accepted, os_count increments. If os_count+1 == NTS, or stop is high, go to FINISH. Otherwise sym_idx wraps to 0 with no gap.
- done=1 in FINISH only if os_count == NTS (not on a stop exit). busy drops and txelecidle rises on the FINISH->IDLE edge. os_count holds until the next start.
- Simultaneous events:
  - start while busy: ignored.
  - start and stop in the same cycle from IDLE: the burst starts and exactly one set is sent.
  - stop and last-set completion in the same cycle: done=1 (count reached wins).
- os_count saturates at NTS; it never wraps.

Test Plan:
- Reset then start with os_type=0, link_num=0x01, lane_num=3, n_fts=0x20, rate_id=0x02, train_ctl=0, sym_ready=1, NTS=4 -> 64 consecutive valid symbols. Each set reads BC,01,03,20,02,00, then 4A x10. done pulses once, 1 cycle after the 64th symbol; os_count=4; txelecidle returns to 1.
- link_pad=1, lane_pad=1 -> symbols 1 and 2 are 0xF7 with txdatak=1.
- Toggle os_type to 1 at symbol 8 of set 2 -> set 2 is still TS1 (4A). Set 3 onward carries 0x45 in symbols 6-15.
- sym_ready low for 5 cycles at symbol 9 -> txdata is held at the same value for the stall duration. No symbol is skipped or duplicated; total of 16 accepted symbols per set.
- Assert stop during set 2 of 4 -> set 2 completes; busy falls; done never pulses; os_count=2.
- Assert reset_n=0 mid-set 3 -> all outputs return to reset values asynchronously. A new start after release begins again at COM with os_count=0.
